// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit: radix-2 restoring division, one
// quotient bit per cycle, with a single-cycle path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Div_Out,
  output logic            Div_Zero
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic            q_neg;
  logic            r_neg;
  logic            op_rem;

  logic            is_signed;
  logic            b_zero;
  logic            ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  // Operand conditioning and special-case detection at accept time
  always_comb begin
    is_signed = ~Op[0];
    b_zero    = (B == '0);
    ovf       = is_signed && (A == INT_MIN) && (B == '1);
    a_mag     = (is_signed && A[XLEN-1]) ? (~A + XLEN'(1)) : A;
    b_mag     = (is_signed && B[XLEN-1]) ? (~B + XLEN'(1)) : B;
    fast_res  = '0;
    if (b_zero) begin
      fast_res = Op[1] ? A : '1;
    end else begin
      fast_res = Op[1] ? '0 : INT_MIN;
    end
  end

  // One restoring step: shift next dividend bit in, trial-subtract over 33 bits
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    q_fix   = q_neg ? (~quo + XLEN'(1)) : quo;
    r_fix   = r_neg ? (~rem + XLEN'(1)) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      op_rem   <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Div_Out  <= '0;
      Div_Zero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (Start) begin
            op_rem <= Op[1];
            if (b_zero || ovf) begin
              Div_Out  <= fast_res;
              Div_Zero <= b_zero;
              Done     <= 1'b1;
              state    <= DONE;
            end else begin
              rem   <= '0;
              quo   <= a_mag;
              dvs   <= b_mag;
              q_neg <= is_signed && ~Op[1] && (A[XLEN-1] ^ B[XLEN-1]);
              r_neg <= is_signed && Op[1] && A[XLEN-1];
              cnt   <= CNT_W'(XLEN);
              Busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          Div_Out  <= op_rem ? r_fix : q_fix;
          Div_Zero <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b1;
          state    <= DONE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// fast paths, ignored Start while busy, back-to-back and mid-operation reset.
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Div_Out;
  logic        Div_Zero;

  int n_cmp;
  int n_err;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .Div_Out  (Div_Out),
    .Div_Zero (Div_Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a one-cycle Start; returns 1ns after the accepting edge
  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  // Issue a request and observe it; lat is cycles after accept (-1 on timeout)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] out, output logic z,
                        output int busy_cycles);
    start_req(op, a, b);
    lat = -1;
    out = 'x;
    z = 1'bx;
    busy_cycles = 0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      if (Busy) busy_cycles++;
      if (Done) begin
        lat = k;
        out = Div_Out;
        z   = Div_Zero;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", Done); end
    n_cmp++; if (Div_Out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h expected 00000000", Div_Out); end
    n_cmp++; if (Div_Zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b expected 0", Div_Zero); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_basic();
    int lat, bc;
    logic [31:0] out;
    logic z;
    run_op(OP_DIV, 32'd100, 32'd7, lat, out, z, bc);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency: got %0d expected 33", lat); end
    n_cmp++; if (bc !== 33) begin n_err++; $display("FAIL div_busy_cycles: got %0d expected 33", bc); end
    n_cmp++; if (out !== 32'd14) begin n_err++; $display("FAIL div_100_7: got %h expected 0000000e", out); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL div_zero_flag: got %b expected 0", z); end
    @(posedge clk);
    #1;
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL div_done_pulse: got %b expected 0", Done); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (Div_Out !== 32'd14) begin n_err++; $display("FAIL div_out_held: got %h expected 0000000e", Div_Out); end
  endtask

  task automatic test_signed_unsigned();
    int lat, bc;
    logic [31:0] out;
    logic z;
    run_op(OP_REM, 32'hFFFFFFF9, 32'd2, lat, out, z, bc);
    n_cmp++; if (out !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rem_neg7_2: got %h expected ffffffff", out); end
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, lat, out, z, bc);
    n_cmp++; if (out !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divu_max_1: got %h expected ffffffff", out); end
    run_op(OP_REMU, 32'hFFFFFFFF, 32'h10, lat, out, z, bc);
    n_cmp++; if (out !== 32'h0000000F) begin n_err++; $display("FAIL remu_max_16: got %h expected 0000000f", out); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL remu_latency: got %0d expected 33", lat); end
    run_op(OP_DIV, 32'hFFFFFF9C, 32'd7, lat, out, z, bc);
    n_cmp++; if (out !== 32'hFFFFFFF2) begin n_err++; $display("FAIL div_neg100_7: got %h expected fffffff2", out); end
    run_op(OP_REM, 32'hFFFFFF9C, 32'd7, lat, out, z, bc);
    n_cmp++; if (out !== 32'hFFFFFFFE) begin n_err++; $display("FAIL rem_neg100_7: got %h expected fffffffe", out); end
    run_op(OP_DIV, 32'h80000000, 32'd2, lat, out, z, bc);
    n_cmp++; if (out !== 32'hC0000000) begin n_err++; $display("FAIL div_min_2: got %h expected c0000000", out); end
    run_op(OP_DIV, 32'd100, 32'hFFFFFFF9, lat, out, z, bc);
    n_cmp++; if (out !== 32'hFFFFFFF2) begin n_err++; $display("FAIL div_100_neg7: got %h expected fffffff2", out); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic [31:0] out;
    logic z;
    run_op(OP_DIV, 32'd5, 32'd0, lat, out, z, bc);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL dz_latency: got %0d expected 0", lat); end
    n_cmp++; if (bc !== 0) begin n_err++; $display("FAIL dz_busy: got %0d expected 0", bc); end
    n_cmp++; if (out !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dz_div: got %h expected ffffffff", out); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b expected 1", z); end
    run_op(OP_REMU, 32'd5, 32'd0, lat, out, z, bc);
    n_cmp++; if (out !== 32'd5) begin n_err++; $display("FAIL dz_remu: got %h expected 00000005", out); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL dz_remu_flag: got %b expected 1", z); end
    run_op(OP_DIVU, 32'd9, 32'd3, lat, out, z, bc);
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL dz_flag_clears: got %b expected 0", z); end
    n_cmp++; if (out !== 32'd3) begin n_err++; $display("FAIL divu_9_3: got %h expected 00000003", out); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [31:0] out;
    logic z;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, out, z, bc);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL ovf_latency: got %0d expected 0", lat); end
    n_cmp++; if (out !== 32'h80000000) begin n_err++; $display("FAIL ovf_div: got %h expected 80000000", out); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL ovf_flag: got %b expected 0", z); end
    run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, lat, out, z, bc);
    n_cmp++; if (out !== 32'h0) begin n_err++; $display("FAIL ovf_rem: got %h expected 00000000", out); end
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL ovf_rem_latency: got %0d expected 0", lat); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, dones;
    logic [31:0] out1, out2;
    start_req(OP_DIVU, 32'd50, 32'd5);
    lat1 = -1;
    dones = 0;
    out1 = 'x;
    for (int k = 0; k < 60 && lat1 < 0; k++) begin
      if (k == 5) begin
        Start = 1'b1; Op = OP_DIV; A = 32'd1; B = 32'd1;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        lat1 = k;
        out1 = Div_Out;
        dones++;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    Start = 1'b0;
    n_cmp++; if (lat1 !== 33) begin n_err++; $display("FAIL b2b_ignore_latency: got %0d expected 33", lat1); end
    n_cmp++; if (out1 !== 32'd10) begin n_err++; $display("FAIL b2b_divu_50_5: got %h expected 0000000a", out1); end
    // new request presented during the DONE cycle
    Start = 1'b1; Op = OP_DIVU; A = 32'd77; B = 32'd7;
    @(posedge clk);
    #1;
    Start = 1'b0;
    lat2 = -1;
    out2 = 'x;
    for (int k = 0; k < 60 && lat2 < 0; k++) begin
      if (Done) begin
        lat2 = k;
        out2 = Div_Out;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++; if (lat2 !== 33) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 33", lat2); end
    n_cmp++; if (out2 !== 32'd11) begin n_err++; $display("FAIL b2b_divu_77_7: got %h expected 0000000b", out2); end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL b2b_single_done: got %0d expected 1", dones); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int dones;
    start_req(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b expected 0", Done); end
    n_cmp++; if (Div_Out !== 32'h0) begin n_err++; $display("FAIL rstmid_out: got %h expected 00000000", Div_Out); end
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      if (Done) dones++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d expected 0", dones); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    Start = 1'b0;
    Op    = 2'b00;
    A     = '0;
    B     = '0;
    test_reset();
    test_div_basic();
    test_signed_unsigned();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit that sits in EX beside the single-cycle ALU.
- The ALU answers its operands in the same cycle. This block is the iterative side of EX: the pipeline issues a request and holds EX while Busy is high.
- Uses radix-2 restoring division, one quotient bit per cycle.
- Results follow RISC-V M-extension semantics, including the divide-by-zero and signed-overflow cases.

Parameters:
XLEN, 32, operand/result width; Op encoding and special-case constants are defined for 32.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
Start  input  1  request; sampled only in IDLE or DONE
Op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; latched with Start
A  input  32  dividend; latched with Start
B  input  32  divisor; latched with Start
Busy  output  1  high in CALC and FIX; the pipeline stalls EX while high
Done  output  1  one-cycle pulse; Div_Out valid in that cycle
Div_Out  output  32  quotient or remainder; held until the next Done
Div_Zero  output  1  latched with Div_Out; 1 if the divisor was 0

Behaviour:
- Reset: on a clk edge with rst=1, go to IDLE; clear Busy, Done, Div_Out, Div_Zero, counter and datapath registers. Applies mid-operation; the in-flight request is dropped with no Done.
- States: IDLE, CALC, FIX, DONE.
- Accept: Start=1 in IDLE or DONE latches Op, A, B.
  - Signed ops (Op[0]=0): operand magnitudes are |A| and |B|; record the quotient sign (A[31]^B[31]) and the remainder sign (A[31]).
  - Unsigned ops: use operands as-is, both signs positive.
- Normal path: accept → CALC with counter=32.
  - Each CALC cycle shifts {rem,quo} left by 1 and trial-subtracts the divisor from rem.
  - If the result is non-negative (33-bit compare), rem = difference and the quotient LSB = 1; otherwise restore, LSB = 0.
  - Decrement the counter; counter reaching 0 after the 32nd iteration → FIX.
- FIX (1 cycle):
  - Negate the quotient if its sign is set and Op is DIV.
  - Negate the remainder if its sign is set and Op is REM.
  - Select the quotient for Op[1]=0, the remainder for Op[1]=1; register into Div_Out; → DONE.
- DONE (1 cycle): Done=1. Start in this cycle is accepted (back-to-back); otherwise → IDLE.
- Latency: Start sampled at edge N → Busy high for cycles N+1..N+33 → Done high in cycle N+34.
- Special cases use a fast path from accept directly to DONE: Done in cycle N+1, Busy never asserted.
  - B=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → A; Div_Zero=1.
  - Signed overflow (Op DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV → 0x80000000; REM → 0; Div_Zero=0.
- Start while Busy=1: ignored; latched operands are unchanged and no extra Done is produced.
- Div_Zero=0 for every non-zero divisor.
- Done is never high in two consecutive cycles unless a fast-path request was accepted in the DONE cycle.
- Div_Out and Div_Zero are stable from Done until the next Done; they are not cleared in IDLE.
- Arithmetic:
  - 33-bit internal remainder for the trial subtraction.
  - Negation is two's complement modulo 2^32, so |0x80000000| is handled as unsigned 0x80000000.
  - Remainder sign follows the dividend.
  - Quotient truncates toward zero.

Test Plan:
- DIV A=100, B=7, Start at cycle N → Busy 1 for N+1..N+33; Done only at N+34; Div_Out=14.
- REM A=0xFFFFFFF9 (-7), B=2 → Div_Out=0xFFFFFFFF (-1). DIVU A=0xFFFFFFFF, B=1 → 0xFFFFFFFF. REMU A=0xFFFFFFFF, B=0x10 → 0xF.
- Divide by zero:
  - DIV A=5, B=0 → Done at N+1; Div_Out=0xFFFFFFFF; Div_Zero=1; Busy stays 0.
  - REMU A=5, B=0 → Div_Out=5.
- Overflow: DIV A=0x80000000, B=0xFFFFFFFF → Div_Out=0x80000000 at N+1. REM with the same operands → 0.
- Start pulse with A=1, B=1 during CALC of DIVU 50/5 → ignored; Done exactly once, Div_Out=10. A new Start in the DONE cycle → second result 34 cycles later.
- rst=1 at cycle N+10 of an active DIV → next cycle: IDLE, Busy=0, Done=0, Div_Out=0; no Done follows until a new Start.
